// File: rtl/decompressor_job_ctrl.sv
// Job controller for a decompressor core: metadata queue, launch/run/flush
// sequencing, beat counting, timeout supervision and completion reporting.
module decompressor_job_ctrl #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CLEN_W      = 35,
    parameter int DLEN_W      = 32,
    parameter int ID_W        = 4,
    parameter int TO_W        = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           meta_valid,
    output logic                           meta_ready,
    input  logic [CLEN_W-1:0]              compression_length,
    input  logic [DLEN_W-1:0]              decompression_length,
    input  logic [ID_W-1:0]                meta_id,
    output logic                           core_start,
    output logic [CLEN_W-1:0]              core_compression_length,
    output logic [DLEN_W-1:0]              core_decompression_length,
    input  logic                           core_done,
    input  logic                           core_out_valid,
    input  logic                           core_out_ready,
    input  logic                           abort,
    output logic                           core_flush,
    output logic                           job_done_valid,
    input  logic                           job_done_ready,
    output logic [ID_W-1:0]                job_done_id,
    output logic [1:0]                     job_done_status,
    output logic [DLEN_W-1:0]              job_done_beats,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level
);

    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int QLW = PW + 1;
    localparam logic [QLW-1:0] DEPTH_L = QLW'(QUEUE_DEPTH);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_FLUSH,
        S_REPORT
    } state_e;

    state_e state_q, state_d;

    // Metadata queue storage and pointers
    logic [CLEN_W-1:0] q_clen_q [QUEUE_DEPTH];
    logic [DLEN_W-1:0] q_dlen_q [QUEUE_DEPTH];
    logic [ID_W-1:0]   q_id_q   [QUEUE_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [QLW-1:0]    level_q, level_d;

    // Active job registers and counters
    logic [CLEN_W-1:0] job_clen_q;
    logic [DLEN_W-1:0] job_dlen_q;
    logic [ID_W-1:0]   job_id_q;
    logic [DLEN_W-1:0] beats_q;
    logic [TO_W-1:0]   to_q;
    logic [1:0]        status_q;
    logic              flush_cnt_q;

    logic push;
    logic pop;
    logic load;
    logic beat;
    logic to_full;

    assign meta_ready = (level_q != DEPTH_L);
    assign push       = meta_valid & meta_ready;
    assign pop        = (state_q == S_LAUNCH);
    // Job registers capture the head one cycle ahead so they are valid
    // during the start pulse; the entry itself is retired in LAUNCH.
    assign load       = (state_q == S_IDLE) && (level_q != '0);
    assign beat       = core_out_valid & core_out_ready;
    assign to_full    = (to_q == '1);

    // Queue pointer and level bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + QLW'(1);
            2'b01:   level_d = level_q - QLW'(1);
            default: level_d = level_q;
        endcase
    end

    // Queue pointer/level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Queue entry write on accepted metadata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_clen_q[i] <= '0;
                q_dlen_q[i] <= '0;
                q_id_q[i]   <= '0;
            end
        end else if (push) begin
            q_clen_q[wr_ptr_q] <= compression_length;
            q_dlen_q[wr_ptr_q] <= decompression_length;
            q_id_q[wr_ptr_q]   <= meta_id;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (job_dlen_q == '0) begin
                    state_d = S_REPORT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_REPORT;
                end else if (abort || to_full) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (job_done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        core_start     = 1'b0;
        core_flush     = 1'b0;
        job_done_valid = 1'b0;
        busy           = (state_q != S_IDLE);
        unique case (state_q)
            S_LAUNCH: core_start     = (job_dlen_q != '0);
            S_FLUSH:  core_flush     = 1'b1;
            S_REPORT: job_done_valid = 1'b1;
            default:  ;
        endcase
    end

    // Job registers, held from capture until the report is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_clen_q <= '0;
            job_dlen_q <= '0;
            job_id_q   <= '0;
        end else if (load) begin
            job_clen_q <= q_clen_q[rd_ptr_q];
            job_dlen_q <= q_dlen_q[rd_ptr_q];
            job_id_q   <= q_id_q[rd_ptr_q];
        end
    end

    // Beat/timeout counters and completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            to_q     <= '0;
            status_q <= ST_OK;
        end else begin
            unique case (state_q)
                S_LAUNCH: begin
                    beats_q  <= '0;
                    to_q     <= '0;
                    status_q <= ST_OK;
                end
                S_RUN: begin
                    if (beat && (beats_q != '1)) begin
                        beats_q <= beats_q + DLEN_W'(1);
                    end
                    to_q <= beat ? '0 : to_q + TO_W'(1);
                    if (core_done) begin
                        status_q <= ST_OK;
                    end else if (abort) begin
                        status_q <= ST_ABORT;
                    end else if (to_full) begin
                        status_q <= ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-cycle flush length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= 1'b0;
        end else begin
            flush_cnt_q <= (state_q == S_FLUSH) ? ~flush_cnt_q : 1'b0;
        end
    end

    assign core_compression_length   = job_clen_q;
    assign core_decompression_length = job_dlen_q;
    assign job_done_id               = job_id_q;
    assign job_done_status           = status_q;
    assign job_done_beats            = beats_q;
    assign queue_level               = level_q;

endmodule

// File: doc/decompressor_job_ctrl.md
DECOMPRESSOR_JOB_CTRL -- requirements
Module: decompressor_job_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, metadata queue entries (power of 2, >=2).
REQ-002 SHALL have parameter CLEN_W, default 35, compressed-length width.
REQ-003 SHALL have parameter DLEN_W, default 32, decompressed-length and beat-count width.
REQ-004 SHALL have parameter ID_W, default 4, job-ID width.
REQ-005 SHALL have parameter TO_W, default 24, timeout-counter width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- meta_valid / meta_ready  in / out  1  job metadata handshake.
- compression_length  in  CLEN_W  compressed length of job.
- decompression_length  in  DLEN_W  decompressed length of job.
- meta_id  in  ID_W  job tag.
- core_start  out  1  one-cycle start pulse to decompressor core.
- core_compression_length  out  CLEN_W  length to core.
- core_decompression_length  out  DLEN_W  length to core.
- core_done  in  1  core finished current job.
- core_out_valid / core_out_ready  in / in  1  monitored core output handshake.
- abort  in  1  cancel active job.
- core_flush  out  1  soft-reset request to core.
- job_done_valid / job_done_ready  out / in  1  completion-report handshake.
- job_done_id  out  ID_W  tag of reported job.
- job_done_status  out  2  00 OK, 01 TIMEOUT, 10 ABORT.
- job_done_beats  out  DLEN_W  accepted output beats of job.
- busy  out  1  FSM not in IDLE.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  entries held in queue.

Function
REQ-007 Queue SHALL be a FIFO of {compression_length, decompression_length, meta_id}; push on meta_valid&meta_ready; meta_ready = (queue_level != QUEUE_DEPTH), no full-bypass.
REQ-008 Push and pop in same cycle SHALL leave queue_level unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-009 FSM states SHALL be IDLE, LAUNCH, RUN, FLUSH, REPORT.
REQ-010 IDLE: queue non-empty -> LAUNCH; otherwise stay.
REQ-011 LAUNCH (one cycle): pop head into job registers; core_start=1 exactly this cycle; clear beat and timeout counters; -> RUN. If popped decompression_length==0: core_start stays 0, status OK, beats 0, -> REPORT.
REQ-012 core_compression_length / core_decompression_length / job_done_id SHALL be registered at LAUNCH and held stable until the REPORT handshake completes.
REQ-013 RUN: beat counter +1 on each core_out_valid&core_out_ready, saturating at all-ones; timeout counter cleared on each beat, else +1.
REQ-014 RUN exits, priority highest first: core_done -> REPORT, status OK; abort -> FLUSH, status ABORT; timeout counter all-ones -> FLUSH, status TIMEOUT.
REQ-015 FLUSH SHALL assert core_flush for exactly 2 cycles, then -> REPORT.
REQ-016 REPORT: job_done_valid=1 and all job_done_* held until job_done_ready; on handshake -> IDLE.
REQ-017 abort SHALL be ignored in IDLE, LAUNCH, FLUSH and REPORT.
REQ-018 Latency: meta accepted in cycle t with FSM IDLE and queue empty -> core_start in cycle t+2.
REQ-019 Metadata pushes SHALL continue while a job is in RUN/FLUSH/REPORT.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, empty queue, zero counters and job registers.
REQ-021 Output values during and after reset: meta_ready=1, queue_level=0, busy=0, core_start=0, core_flush=0, job_done_valid=0, all data outputs 0.
REQ-022 Reset mid-job SHALL discard the active job and all queued jobs; no report is produced.

Verification
REQ-023 Single job (clen=100, dlen=256, id=3): 4 beats, then core_done -> core_start in cycle t+2, report id=3, status 00, beats=4.
REQ-024 Fill queue with 5 jobs during RUN (depth 4): meta_ready drops after the 4th queued entry; jobs report in order of acceptance.
REQ-025 Abort in RUN after 2 beats -> core_flush high exactly 2 cycles; report status 10, beats=2; abort in IDLE -> no effect.
REQ-026 TO_W=4, no beats after start -> core_flush after 15 idle RUN cycles; status 01; core_done and abort in same cycle -> status 00.
REQ-027 dlen=0 job -> no core_start; report status 00, beats 0; job_done_ready held low 10 cycles -> outputs stable throughout.
REQ-028 rst_n asserted asynchronously mid-RUN with 2 jobs queued -> outputs reach reset values before next clock edge; queue_level=0.
